// File: rtl/dm_completion_queue.sv
// Completion-status queue for the data movers: 64-bit records drained over a 32-bit MMIO port.
// Optional sequence numbering is enabled by defining DM_COMPLETION_SEQ_EN.
module dm_completion_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DEST_WIDTH = 3,
    parameter int USER_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  src_done,
    input  logic [14:0]           src_len,
    input  logic [DEST_WIDTH-1:0] src_dest,
    input  logic [USER_WIDTH-1:0] src_user,
    input  logic                  dst_done,
    input  logic [14:0]           dst_len,
    input  logic                  mmio_en,
    input  logic [3:0]            mmio_we,
    input  logic [11:0]           mmio_addr,
    input  logic [31:0]           mmio_wrdata,
    output logic [31:0]           mmio_rddata,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [63:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d, dst_slot;
    logic [CW-1:0]         count_q, count_d, free_space;
    logic [15:0]           ovf_q, ovf_d;
    logic [16:0]           ovf_sum;
    logic [31:0]           rddata_q, rddata_d;
    logic                  irq_q, irq_d;
    logic [31:0]           src_seq, dst_seq;
    logic [31:0]           seq_cur;
    logic                  src_acc, dst_acc, rd_en, pop, ovf_clr;
    logic [1:0]            n_acc, n_drop;
    logic [63:0]           src_rec, dst_rec, head;
    logic                  unused_ok;

    // Write data carries no information: any full-word write to 0x008 is a clear.
    assign unused_ok = ^mmio_wrdata;

`ifdef DM_COMPLETION_SEQ_EN
    logic [31:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q + 32'(n_acc);
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign seq_cur = seq_q;
    assign src_seq = seq_q;
    assign dst_seq = seq_q + 32'(src_acc);
`else
    assign seq_cur = '0;
    assign src_seq = '0;
    assign dst_seq = '0;
`endif

    // Free space uses the pre-pop count, so a pop never makes room for a same-cycle push.
    always_comb begin
        free_space = DEPTH_CNT - count_q;
        src_acc    = src_done && (free_space != '0);
        dst_acc    = dst_done && (src_done ? (free_space >= CW'(2)) : (free_space != '0));
        n_acc      = {1'b0, src_acc} + {1'b0, dst_acc};
        n_drop     = ({1'b0, src_done} + {1'b0, dst_done}) - n_acc;
        dst_slot   = wptr_q + DEPTH_LOG2'(src_acc);

        src_rec = {1'b0, src_len, 8'(src_user), 3'(src_dest), 5'b0, src_seq};
        dst_rec = {1'b1, dst_len, 8'b0, 3'b0, 5'b0, dst_seq};
        head    = mem_q[rptr_q];

        rd_en   = mmio_en && (mmio_we == 4'h0);
        pop     = rd_en && (mmio_addr == 12'h004) && (count_q != '0);
        ovf_clr = mmio_en && (mmio_we == 4'hF) && (mmio_addr == 12'h008);

        wptr_d  = wptr_q + DEPTH_LOG2'(n_acc);
        rptr_d  = rptr_q + DEPTH_LOG2'(pop);
        count_d = count_q + CW'(n_acc) - CW'(pop);
        irq_d   = (count_d != '0);

        ovf_sum = {1'b0, ovf_q} + 17'(n_drop);
        if (ovf_clr) begin
            ovf_d = '0;
        end else if (ovf_sum[16]) begin
            ovf_d = 16'hFFFF;
        end else begin
            ovf_d = ovf_sum[15:0];
        end

        rddata_d = rddata_q;
        if (mmio_en) begin
            case (mmio_addr)
                12'h000: rddata_d = (count_q != '0) ? head[31:0]  : 32'h0;
                12'h004: rddata_d = (count_q != '0) ? head[63:32] : 32'h0;
                12'h008: rddata_d = {ovf_q, {(15 - DEPTH_LOG2){1'b0}}, count_q};
                12'h00C: rddata_d = seq_cur;
                default: rddata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (src_acc) begin
            mem_q[wptr_q] <= src_rec;
        end
        if (dst_acc) begin
            mem_q[dst_slot] <= dst_rec;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            rddata_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rddata_q <= rddata_d;
            irq_q    <= irq_d;
        end
    end

    assign mmio_rddata = rddata_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_dm_completion_queue.sv
// Bench for dm_completion_queue: directed plan steps plus random traffic against a queue-based model.
// Honours DM_COMPLETION_SEQ_EN the same way the design does.
module tb_dm_completion_queue;

    localparam int DEPTH = 16;
`ifdef DM_COMPLETION_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        rst = 1'b0;
    logic        src_done = 1'b0;
    logic [14:0] src_len = '0;
    logic [2:0]  src_dest = '0;
    logic [7:0]  src_user = '0;
    logic        dst_done = 1'b0;
    logic [14:0] dst_len = '0;
    logic        mmio_en = 1'b0;
    logic [3:0]  mmio_we = '0;
    logic [11:0] mmio_addr = '0;
    logic [31:0] mmio_wrdata = '0;
    logic [31:0] mmio_rddata;
    logic        irq;

    dm_completion_queue #(.DEPTH_LOG2(4), .DEST_WIDTH(3), .USER_WIDTH(8)) dut (
        .aclk(aclk), .rst(rst),
        .src_done(src_done), .src_len(src_len), .src_dest(src_dest), .src_user(src_user),
        .dst_done(dst_done), .dst_len(dst_len),
        .mmio_en(mmio_en), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wrdata(mmio_wrdata),
        .mmio_rddata(mmio_rddata), .irq(irq)
    );

    initial forever #5 aclk = ~aclk;

    // Reference model: a plain record queue plus counters.
    logic [63:0] mq[$];
    int unsigned m_ovf = 0;
    logic [31:0] m_seq = '0;
    logic [31:0] m_rd = '0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        logic [31:0] v;
        case (addr)
            12'h000: v = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
            12'h004: v = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
            12'h008: v = {m_ovf[15:0], 11'b0, 5'(mq.size())};
            12'h00C: v = SEQ_EN ? m_seq : 32'h0;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Drives one cycle of inputs, advances the model, then checks irq and read data after the edge.
    task automatic applyStimulus(input string tag, input logic rs,
                                 input logic s, input logic [14:0] slen, input logic [2:0] sdest,
                                 input logic [7:0] suser, input logic d, input logic [14:0] dlen,
                                 input logic en, input logic [3:0] we, input logic [11:0] addr,
                                 input logic [31:0] wd);
        int slots;
        int drops;
        rst = rs; src_done = s; src_len = slen; src_dest = sdest; src_user = suser;
        dst_done = d; dst_len = dlen; mmio_en = en; mmio_we = we; mmio_addr = addr; mmio_wrdata = wd;
        if (rs) begin
            mq.delete();
            m_ovf = 0;
            m_seq = '0;
            m_rd  = '0;
        end else begin
            slots = DEPTH - mq.size();
            drops = 0;
            if (en) m_rd = modelRead(addr);
            if (en && we == 4'h0 && addr == 12'h004 && mq.size() > 0) void'(mq.pop_front());
            if (s) begin
                if (slots > 0) begin
                    mq.push_back({1'b0, slen, suser, sdest, 5'b0, SEQ_EN ? m_seq : 32'h0});
                    m_seq++;
                    slots--;
                end else drops++;
            end
            if (d) begin
                if (slots > 0) begin
                    mq.push_back({1'b1, dlen, 8'h0, 3'h0, 5'b0, SEQ_EN ? m_seq : 32'h0});
                    m_seq++;
                    slots--;
                end else drops++;
            end
            if (en && we == 4'hF && addr == 12'h008) m_ovf = 0;
            else if (m_ovf + drops > 65535) m_ovf = 65535;
            else m_ovf = m_ovf + drops;
        end
        @(posedge aclk);
        #1;
        rst = 1'b0; src_done = 1'b0; dst_done = 1'b0; mmio_en = 1'b0; mmio_we = '0;
        checkOutput({tag, "_irq"}, 32'(irq), 32'(mq.size() != 0));
        checkOutput({tag, "_rd"}, mmio_rddata, m_rd);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 4'h0, 12'h0, 32'h0);
    endtask

    task automatic readReg(input string tag, input logic [11:0] addr);
        applyStimulus(tag, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic writeReg(input string tag, input logic [11:0] addr, input logic [3:0] we);
        applyStimulus(tag, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, we, addr, $urandom);
    endtask

    task automatic pulse(input string tag, input logic s, input logic [14:0] slen,
                         input logic [2:0] sdest, input logic [7:0] suser,
                         input logic d, input logic [14:0] dlen);
        applyStimulus(tag, 1'b0, s, slen, sdest, suser, d, dlen, 1'b0, 4'h0, 12'h0, 32'h0);
    endtask

    initial begin
        int unsigned bias;
        int unsigned op;
        logic [11:0] a;
        logic [3:0]  w;
        logic        e;

        doReset("reset0");
        doReset("reset1");
        checkOutput("reset_rd", mmio_rddata, 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        readReg("reset_stat", 12'h008);
        checkOutput("reset_stat_const", mmio_rddata, 32'h0);

        // Single src completion
        pulse("single_push", 1'b1, 15'h10, 3'd2, 8'hA5, 1'b0, '0);
        checkOutput("single_irq_const", 32'(irq), 32'h1);
        readReg("single_lo", 12'h000);
        checkOutput("single_lo_const", mmio_rddata, 32'h0);
        readReg("single_hi", 12'h004);
        checkOutput("single_hi_const", mmio_rddata, 32'h0010A540);
        readReg("single_stat", 12'h008);
        checkOutput("single_stat_const", mmio_rddata, 32'h0);
        checkOutput("single_irq_fall", 32'(irq), 32'h0);

        // Simultaneous src and dst into an empty queue
        doReset("both_rst");
        pulse("both_push", 1'b1, 15'd1, 3'd0, 8'h00, 1'b1, 15'd2);
        readReg("both_stat", 12'h008);
        checkOutput("both_stat_const", mmio_rddata, 32'h2);
        readReg("both_lo0", 12'h000);
        checkOutput("both_seq0_const", mmio_rddata, 32'h0);
        readReg("both_hi0", 12'h004);
        checkOutput("both_hi0_const", mmio_rddata, 32'h00010000);
        readReg("both_lo1", 12'h000);
        checkOutput("both_seq1_const", mmio_rddata, SEQ_EN ? 32'h1 : 32'h0);
        readReg("both_hi1", 12'h004);
        checkOutput("both_hi1_const", mmio_rddata, 32'h80020000);

        // Overflow with 17 pulses, then clear
        doReset("ovf_rst");
        for (int i = 0; i < 17; i++) pulse("ovf_push", 1'b1, 15'(i), 3'(i), 8'(i), 1'b0, '0);
        readReg("ovf_stat", 12'h008);
        checkOutput("ovf_stat_const", mmio_rddata, 32'h00010010);
        writeReg("ovf_clr", 12'h008, 4'hF);
        readReg("ovf_stat2", 12'h008);
        checkOutput("ovf_clr_const", mmio_rddata, 32'h00000010);

        // One slot left when both pulses arrive
        doReset("one_rst");
        for (int i = 0; i < 15; i++) pulse("one_fill", 1'b1, 15'(i + 3), 3'd1, 8'h3C, 1'b0, '0);
        pulse("one_both", 1'b1, 15'h7ABC, 3'd5, 8'hEE, 1'b1, 15'h1234);
        readReg("one_stat", 12'h008);
        checkOutput("one_stat_const", mmio_rddata, 32'h00010010);
        for (int i = 0; i < 16; i++) begin
            readReg("one_lo", 12'h000);
            readReg("one_hi", 12'h004);
        end
        checkOutput("one_last_hi_const", mmio_rddata, {1'b0, 15'h7ABC, 8'hEE, 3'd5, 5'b0});

        // Empty-queue reads
        doReset("empty_rst");
        readReg("empty_hi0", 12'h004);
        readReg("empty_lo", 12'h000);
        readReg("empty_hi1", 12'h004);
        checkOutput("empty_hi_const", mmio_rddata, 32'h0);
        readReg("empty_stat", 12'h008);
        checkOutput("empty_stat_const", mmio_rddata, 32'h0);

        // Reset with records queued, with a pulse lost in the reset cycle
        for (int i = 0; i < 5; i++) pulse("mid_push", 1'b1, 15'(i + 1), 3'd7, 8'h11, 1'b1, 15'(i));
        applyStimulus("mid_rst", 1'b1, 1'b1, 15'h55, 3'd3, 8'h99, 1'b1, 15'h66, 1'b0, 4'h0, 12'h0, 32'h0);
        checkOutput("mid_irq_const", 32'(irq), 32'h0);
        readReg("mid_stat", 12'h008);
        checkOutput("mid_stat_const", mmio_rddata, 32'h0);
        readReg("mid_seq", 12'h00C);
        checkOutput("mid_seq_const", mmio_rddata, 32'h0);

        // Wrap-around with push/pop pairs
        for (int i = 0; i < 40; i++) begin
            pulse("wrap_push", 1'b1, 15'($urandom), 3'($urandom), 8'($urandom), 1'b0, '0);
            readReg("wrap_lo", 12'h000);
            checkOutput("wrap_seq_const", mmio_rddata, SEQ_EN ? 32'(i) : 32'h0);
            readReg("wrap_hi", 12'h004);
        end

        // Random traffic: alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 800; i++) begin
            bias = ((i / 100) % 2 == 0) ? 60 : 15;
            op = $urandom_range(9);
            e = 1'b1;
            w = 4'h0;
            case (op)
                0, 1, 2, 3: a = 12'h004;
                4:          a = 12'h000;
                5:          a = 12'h008;
                6:          a = 12'h00C;
                7:          a = 12'h010 + 12'($urandom_range(255) * 4);
                8:          begin a = 12'h008; w = 4'hF; end
                default:    begin a = 12'h008; w = 4'h3; e = ($urandom_range(1) == 1); end
            endcase
            applyStimulus("rand", ($urandom_range(199) == 0),
                          ($urandom_range(99) < bias), 15'($urandom), 3'($urandom), 8'($urandom),
                          ($urandom_range(99) < bias), 15'($urandom),
                          e, w, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
